// File: rtl/instr_mem_fetch_pkg.sv
//==============================================================================
// Module      : instr_mem_fetch_pkg
// Description : Shared types and defaults for the IITB RISC instruction memory
//               with fetch handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package instr_mem_fetch_pkg;

  // Encoding of the IITB RISC no-operation instruction; also returned for
  // out-of-range fetches.
  localparam logic [15:0] NOP_WORD_DEFAULT = 16'hF000;

  // Lifecycle of the memory: clear to NOP, accept a program, then serve fetches.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_PROG = 2'd1,
    ST_RUN  = 2'd2
  } ifm_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_fetch_if.sv
//==============================================================================
// Module      : instr_mem_fetch_if
// Description : Program-load and fetch/response bundle between the PC/fetch
//               stage (master) and the instruction memory (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface instr_mem_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // Program load port
  logic              prog_ready;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_done;
  logic              prog_err;

  // Fetch request
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              stall;
  logic              flush;

  // Registered response towards IF/ID
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_oob;

  modport master (
    input  prog_ready, prog_err, fetch_ready,
    input  instr_valid, instr, instr_addr, instr_oob,
    output prog_we, prog_addr, prog_data, prog_done,
    output fetch_req, fetch_addr, stall, flush
  );

  modport slave (
    output prog_ready, prog_err, fetch_ready,
    output instr_valid, instr, instr_addr, instr_oob,
    input  prog_we, prog_addr, prog_data, prog_done,
    input  fetch_req, fetch_addr, stall, flush
  );

endinterface

`default_nettype wire

// File: rtl/instr_mem_fetch_array.sv
//==============================================================================
// Module      : instr_mem_fetch_array
// Description : DEPTH x DATA_W storage, one synchronous write port and one
//               asynchronous read port. No reset: contents are cleared by the
//               owning block's INIT sweep.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_mem_fetch_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port; the caller guarantees waddr_i < DEPTH when we_i is high.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read; an out-of-range raddr_i is masked by the caller.
  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/instr_mem_fetch.sv
//==============================================================================
// Module      : instr_mem_fetch
// Description : Programmable instruction memory for the IITB RISC core.
//               Clears itself to NOP after reset, accepts a program over the
//               load port, then serves one fetch per cycle with a registered
//               response (latency 1), honouring stall and flush.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_mem_fetch
  import instr_mem_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  instr_mem_fetch_if.slave   bus
);

  // Index width into the array; a one-word memory still needs one bit.
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                AW1       = ADDR_W + 1;
  // DEPTH widened by one bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT = AW1'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  ifm_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              prog_err_q, prog_err_d;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
  logic              oob_q, oob_d;

  logic              prog_in_range;
  logic              fetch_in_range;
  logic              fetch_ready;
  logic              accept;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Unsigned range checks; addresses never wrap into the array.
  assign prog_in_range  = {1'b0, bus.prog_addr}  < DEPTH_EXT;
  assign fetch_in_range = {1'b0, bus.fetch_addr} < DEPTH_EXT;

  // A held response under stall blocks new requests; flush drops the request.
  assign fetch_ready = (state_q == ST_RUN) && !bus.flush && !(valid_q && bus.stall);
  assign accept      = bus.fetch_req && fetch_ready;

  //----------------------------------------------------------------------------
  // Lifecycle FSM
  //----------------------------------------------------------------------------

  // State and clear-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: INIT sweeps every word once, PROG waits for prog_done, RUN is terminal.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_PROG;
          cnt_d   = '0;
        end
      end
      ST_PROG: begin
        if (bus.prog_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Write-port mux and load-port error
  //----------------------------------------------------------------------------

  // INIT owns the write port; in PROG the load port writes only in-range words.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = NOP_WORD;
    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
    end else if ((state_q == ST_PROG) && bus.prog_we && prog_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = bus.prog_addr[IDX_W-1:0];
      mem_wdata = bus.prog_data;
    end
  end

  // Writes while clearing are silently ignored; only PROG range errors and RUN writes flag.
  assign prog_err_d = bus.prog_we &&
                      (((state_q == ST_PROG) && !prog_in_range) || (state_q == ST_RUN));

  // One-cycle error pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_err_q <= 1'b0;
    end else begin
      prog_err_q <= prog_err_d;
    end
  end

  instr_mem_fetch_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (bus.fetch_addr[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  //----------------------------------------------------------------------------
  // Response register
  //----------------------------------------------------------------------------

  // Capture on accept; otherwise hold under stall, else retire (flush always retires).
  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    oob_d        = oob_q;
    if (accept) begin
      valid_d      = 1'b1;
      instr_addr_d = bus.fetch_addr;
      oob_d        = !fetch_in_range;
      instr_d      = fetch_in_range ? mem_rdata : NOP_WORD;
    end else if (bus.flush || !(valid_q && bus.stall)) begin
      valid_d = 1'b0;
    end
  end

  // Response registers presented to IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      instr_q      <= NOP_WORD;
      instr_addr_q <= '0;
      oob_q        <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      oob_q        <= oob_d;
    end
  end

  assign bus.prog_ready  = (state_q == ST_PROG);
  assign bus.prog_err    = prog_err_q;
  assign bus.fetch_ready = fetch_ready;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = instr_addr_q;
  assign bus.instr_oob   = oob_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_fetch.sv
//==============================================================================
// Module      : tb_instr_mem_fetch
// Description : Self-checking bench for instr_mem_fetch: a phase/memory model
//               compared every cycle, plus directed hand-computed checks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_mem_fetch;

  localparam int          ADDR_W = 16;
  localparam int          DATA_W = 16;
  localparam int          DEPTH  = 64;
  localparam logic [15:0] NOP    = 16'hF000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  instr_mem_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_mem_fetch #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  //----------------------------------------------------------------------------
  // Reference model: lifecycle phase, program contents, pending response
  //----------------------------------------------------------------------------
  typedef enum {M_INIT, M_PROG, M_RUN} mphase_t;

  mphase_t     m_phase;
  int          m_init_n;
  logic [15:0] m_mem [DEPTH];
  logic        m_valid;
  logic [15:0] m_instr;
  logic [15:0] m_addr;
  logic        m_oob;
  logic        m_perr;

  function automatic logic m_ready();
    return (m_phase == M_RUN) && !bus.flush && !(m_valid && bus.stall);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  <= M_INIT;
      m_init_n <= 0;
      m_valid  <= 1'b0;
      m_instr  <= NOP;
      m_addr   <= '0;
      m_oob    <= 1'b0;
      m_perr   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= NOP;
    end else begin
      if (bus.fetch_req && m_ready()) begin
        m_valid <= 1'b1;
        m_addr  <= bus.fetch_addr;
        if (int'(bus.fetch_addr) < DEPTH) begin
          m_instr <= m_mem[bus.fetch_addr[5:0]];
          m_oob   <= 1'b0;
        end else begin
          m_instr <= NOP;
          m_oob   <= 1'b1;
        end
      end else if (!(m_valid && bus.stall && !bus.flush)) begin
        m_valid <= 1'b0;
      end
      m_perr <= bus.prog_we &&
                ((m_phase == M_RUN) || ((m_phase == M_PROG) && int'(bus.prog_addr) >= DEPTH));
      case (m_phase)
        M_INIT: begin
          m_init_n <= m_init_n + 1;
          if (m_init_n == DEPTH - 1) m_phase <= M_PROG;
        end
        M_PROG: begin
          if (bus.prog_we && int'(bus.prog_addr) < DEPTH) m_mem[bus.prog_addr[5:0]] <= bus.prog_data;
          if (bus.prog_done) m_phase <= M_RUN;
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    #1;
    check("cyc_instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    check("cyc_instr",       32'(bus.instr),       32'(m_instr));
    check("cyc_instr_addr",  32'(bus.instr_addr),  32'(m_addr));
    check("cyc_instr_oob",   32'(bus.instr_oob),   32'(m_oob));
    check("cyc_prog_ready",  32'(bus.prog_ready),  32'(m_phase == M_PROG));
    check("cyc_prog_err",    32'(bus.prog_err),    32'(m_perr));
    check("cyc_fetch_ready", 32'(bus.fetch_ready), 32'(m_ready()));
  end

  //----------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  //----------------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  task automatic expect_resp(input string name, input logic v, input logic [15:0] ins,
                             input logic [15:0] a, input logic oob);
    check({name, "_valid"}, 32'(bus.instr_valid), 32'(v));
    check({name, "_instr"}, 32'(bus.instr),       32'(ins));
    check({name, "_addr"},  32'(bus.instr_addr),  32'(a));
    check({name, "_oob"},   32'(bus.instr_oob),   32'(oob));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;
    bus.prog_done  = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    reset          = 1'b1;
    cyc();
    cyc();
    expect_resp("reset", 1'b0, 16'hF000, 16'h0000, 1'b0);
    check("reset_prog_ready",  32'(bus.prog_ready),  0);
    check("reset_fetch_ready", 32'(bus.fetch_ready), 0);

    // Clearing sweep must last exactly DEPTH cycles.
    reset = 1'b0;
    n = 0;
    while (!bus.prog_ready && n < 200) begin
      cyc();
      n++;
    end
    check("init_cycles", n, 64);

    // Program load, including one out-of-range write.
    bus.prog_we = 1'b1; bus.prog_addr = 16'd0; bus.prog_data = 16'h0046; cyc();
    bus.prog_addr = 16'd1;  bus.prog_data = 16'h0087; cyc();
    bus.prog_addr = 16'd5;  bus.prog_data = 16'hBEEF; cyc();
    check("prog_err_inrange", 32'(bus.prog_err), 0);
    bus.prog_addr = 16'd70; bus.prog_data = 16'h1234; cyc();
    check("prog_err_oob", 32'(bus.prog_err), 1);
    // Write coinciding with prog_done is still taken.
    bus.prog_addr = 16'd2;  bus.prog_data = 16'h00AA; bus.prog_done = 1'b1; cyc();
    check("prog_err_clear", 32'(bus.prog_err), 0);
    check("run_prog_ready", 32'(bus.prog_ready), 0);
    bus.prog_we = 1'b0; bus.prog_done = 1'b0;

    // Back-to-back fetches.
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 16'd0;  cyc(); expect_resp("fetch0",  1'b1, 16'h0046, 16'd0,  1'b0);
    bus.fetch_addr = 16'd1;  cyc(); expect_resp("fetch1",  1'b1, 16'h0087, 16'd1,  1'b0);
    bus.fetch_addr = 16'd2;  cyc(); expect_resp("fetch2",  1'b1, 16'h00AA, 16'd2,  1'b0);
    bus.fetch_addr = 16'd64; cyc(); expect_resp("fetch64", 1'b1, 16'hF000, 16'd64, 1'b1);
    bus.fetch_addr = 16'd3;  cyc(); expect_resp("fetch3",  1'b1, 16'hF000, 16'd3,  1'b0);
    bus.fetch_addr = 16'd5;  cyc(); expect_resp("fetch5",  1'b1, 16'hBEEF, 16'd5,  1'b0);
    bus.fetch_addr = 16'd1;  cyc(); expect_resp("fetch1b", 1'b1, 16'h0087, 16'd1,  1'b0);

    // Stall with a pending request: response held, nothing accepted.
    bus.stall = 1'b1; bus.fetch_addr = 16'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_fetch_ready", 32'(bus.fetch_ready), 0);
      cyc();
      expect_resp("stall_hold", 1'b1, 16'h0087, 16'd1, 1'b0);
    end

    // Flush under stall drops both the held response and the request.
    bus.flush = 1'b1;
    #1;
    check("flush_fetch_ready", 32'(bus.fetch_ready), 0);
    cyc();
    expect_resp("flush", 1'b0, 16'h0087, 16'd1, 1'b0);

    // Writes in RUN are rejected and flagged.
    bus.flush = 1'b0; bus.stall = 1'b0; bus.fetch_req = 1'b0;
    bus.prog_we = 1'b1; bus.prog_addr = 16'd0; bus.prog_data = 16'h0000;
    cyc();
    check("run_prog_err", 32'(bus.prog_err), 1);
    bus.prog_we = 1'b0;

    // Stall with no valid response does not block acceptance.
    bus.stall = 1'b1; bus.fetch_req = 1'b1; bus.fetch_addr = 16'd0;
    #1;
    check("stall_idle_ready", 32'(bus.fetch_ready), 1);
    cyc();
    expect_resp("stall_idle", 1'b1, 16'h0046, 16'd0, 1'b0);
    bus.stall = 1'b0; bus.fetch_req = 1'b0;
    cyc();
    expect_resp("retire", 1'b0, 16'h0046, 16'd0, 1'b0);
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd1;
    cyc();
    bus.fetch_req = 1'b0;
    expect_resp("pre_reset", 1'b1, 16'h0087, 16'd1, 1'b0);

    // Asynchronous reset in the middle of RUN.
    reset = 1'b1;
    #1;
    expect_resp("midreset", 1'b0, 16'hF000, 16'd0, 1'b0);
    check("midreset_prog_ready",  32'(bus.prog_ready),  0);
    check("midreset_fetch_ready", 32'(bus.fetch_ready), 0);
    check("midreset_prog_err",    32'(bus.prog_err),    0);
    cyc();
    reset = 1'b0;
    n = 0;
    while (!bus.prog_ready && n < 200) begin
      cyc();
      n++;
    end
    check("reinit_cycles", n, 64);
    bus.prog_done = 1'b1; cyc(); bus.prog_done = 1'b0;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 16'd5; cyc(); expect_resp("reinit5", 1'b1, 16'hF000, 16'd5, 1'b0);
    bus.fetch_addr = 16'd0; cyc(); expect_resp("reinit0", 1'b1, 16'hF000, 16'd0, 1'b0);
    bus.fetch_req = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
